aes_shift_rows_pipe: RTL and testbench

AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

---
 rtl/aes_shift_rows_pipe.sv | 119 +++++++++++
 tb/tb_aes_shift_rows_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_pipe.sv
//------------------------------------------------------------------------------
// Module   : aes_shift_rows_pipe
// Purpose  : Rijndael ShiftRows / InvShiftRows behind a 2-entry skid buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_shift_rows_pipe #(
  parameter int NB = 4,
  parameter int W  = 32 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:W-1] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:W-1] out_data
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end

  localparam int ROW_OFS_2 = (NB == 8) ? 3 : 2;
  localparam int ROW_OFS_3 = (NB == 8) ? 4 : 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  logic [0:W-1] w_fwd;
  logic [0:W-1] w_inv;
  logic [0:W-1] w_shift;
  logic         w_accept;
  logic         w_emit;

  occ_e         state_q, state_d;
  logic [0:W-1] main_q, main_d;
  logic [0:W-1] skid_q, skid_d;
  logic         in_ready_q;
  logic         out_valid_q;

  // Both directions are pure byte wiring; the inverse source index adds NB
  // before the modulo so it never goes negative.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int CR      = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? ROW_OFS_2 : ROW_OFS_3;
      localparam int FWD_SRC = (c + CR) % NB;
      localparam int INV_SRC = (c + NB - CR) % NB;
      assign w_fwd[8*(4*c+r) +: 8] = in_data[8*(4*FWD_SRC+r) +: 8];
      assign w_inv[8*(4*c+r) +: 8] = in_data[8*(4*INV_SRC+r) +: 8];
    end
  end

  assign w_shift  = in_inv ? w_inv : w_fwd;
  assign w_accept = in_valid && in_ready_q;
  assign w_emit   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          main_d  = w_shift;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          main_d = w_shift;
        end else if (w_accept) begin
          skid_d  = w_shift;
          state_d = ST_FULL;
        end else if (w_emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_emit) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next occupancy so in_ready has
  // no combinational dependence on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_shift_rows_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_aes_shift_rows_pipe
// Purpose  : Directed bench for aes_shift_rows_pipe (NB=4 and NB=8 instances).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_shift_rows_pipe;

  logic         clk;
  logic         rst_n;

  logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [0:127] in_data4, out_data4;
  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [0:255] in_data8, out_data8;

  int tests;
  int failed;

  aes_shift_rows_pipe #(.NB(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .in_data  (in_data4),
    .in_inv   (in_inv4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .out_data (out_data4)
  );

  aes_shift_rows_pipe #(.NB(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .in_data  (in_data8),
    .in_inv   (in_inv8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .out_data (out_data8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row-rotation model: forward gathers from the rotated row, inverse scatters.
  function automatic logic [0:255] model(input int nb, input logic [0:255] d, input logic inv);
    logic [7:0]   row [8];
    logic [0:255] o;
    int           sh;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      sh = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) row[c] = d[8*(4*c+r) +: 8];
      for (int c = 0; c < nb; c++) begin
        if (!inv) o[8*(4*c+r) +: 8] = row[(c+sh)%nb];
        else      o[8*(4*((c+sh)%nb)+r) +: 8] = row[c];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] model4(input logic [0:127] d, input logic inv);
    logic [0:255] t;
    t = model(4, {d, 128'h0}, inv);
    return t[0:127];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [0:127] seq4, fwd4, a4, b4, c4, rnd4, ea, eb, ec;
  logic [0:255] seq8, exp8;
  logic         rinv;
  logic [0:127] sb[$];

  initial begin
    tests  = 0;
    failed = 0;
    seq4   = 128'h000102030405060708090A0B0C0D0E0F;
    fwd4   = 128'h00050A0F04090E03080D02070C01060B;
    seq8   = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

    rst_n = 1'b0;
    in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
    in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    tick();
    tick();
    check("rst_out_valid4", {255'h0, out_valid4}, 256'h0);
    check("rst_in_ready4",  {255'h0, in_ready4},  256'h0);
    check("rst_out_data4",  out_data4, 256'h0);
    check("rst_out_valid8", {255'h0, out_valid8}, 256'h0);

    // in_valid offered in the release cycle must be ignored
    rst_n = 1'b1;
    in_valid4 = 1'b1; in_data4 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    tick();
    check("post_rst_no_accept", {255'h0, out_valid4}, 256'h0);
    check("post_rst_in_ready",  {255'h0, in_ready4},  256'h1);

    // NB=4 forward then inverse round trip
    in_data4 = seq4; in_inv4 = 1'b0; out_ready4 = 1'b1;
    tick();
    check("fwd4_valid", {255'h0, out_valid4}, 256'h1);
    check("fwd4_data",  out_data4, fwd4);
    in_data4 = fwd4; in_inv4 = 1'b1;
    tick();
    check("inv4_valid", {255'h0, out_valid4}, 256'h1);
    check("inv4_data",  out_data4, seq4);
    in_valid4 = 1'b0;
    tick();
    check("drain4_valid", {255'h0, out_valid4}, 256'h0);

    // NB=8 forward then inverse
    in_valid8 = 1'b1; in_data8 = seq8; in_inv8 = 1'b0;
    tick();
    exp8 = model(8, seq8, 1'b0);
    check("fwd8_valid", {255'h0, out_valid8}, 256'h1);
    check("fwd8_col0",  {224'h0, out_data8[0:31]}, 256'h00050E13);
    check("fwd8_data",  out_data8, exp8);
    in_data8 = exp8; in_inv8 = 1'b1; out_ready8 = 1'b1;
    tick();
    check("inv8_data",  out_data8, seq8);
    in_valid8 = 1'b0;
    tick();
    check("drain8_valid", {255'h0, out_valid8}, 256'h0);

    // Backpressure: A and B fill the buffer, C is refused until space frees
    a4 = 128'h3243F6A8_885A308D_313198A2_E0370734;
    b4 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    c4 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    ea = model4(a4, 1'b0);
    eb = model4(b4, 1'b1);
    ec = model4(c4, 1'b0);
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_data4 = a4; in_inv4 = 1'b0;
    tick();
    check("bp_ready_after_a", {255'h0, in_ready4}, 256'h1);
    in_data4 = b4; in_inv4 = 1'b1;
    tick();
    check("bp_full_ready", {255'h0, in_ready4}, 256'h0);
    check("bp_head_a",     out_data4, ea);
    in_data4 = c4; in_inv4 = 1'b0;
    tick();
    check("bp_c_refused", {255'h0, in_ready4}, 256'h0);
    check("bp_hold_valid", {255'h0, out_valid4}, 256'h1);
    check("bp_hold_a",    out_data4, ea);
    out_ready4 = 1'b1;
    tick();
    check("bp_b_valid", {255'h0, out_valid4}, 256'h1);
    check("bp_b_data",  out_data4, eb);
    tick();
    in_valid4 = 1'b0;
    check("bp_c_valid", {255'h0, out_valid4}, 256'h1);
    check("bp_c_data",  out_data4, ec);
    tick();
    check("bp_empty", {255'h0, out_valid4}, 256'h0);

    // Streaming: one random state per cycle, mixed modes
    in_valid4 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rnd4 = {$urandom, $urandom, $urandom, $urandom};
      rinv = 1'($urandom_range(0, 1));
      in_data4 = rnd4; in_inv4 = rinv;
      sb.push_back(model4(rnd4, rinv));
      tick();
      check("stream_valid", {255'h0, out_valid4}, 256'h1);
      check("stream_data",  out_data4, sb.pop_front());
    end
    in_valid4 = 1'b0;
    tick();
    check("stream_drain", {255'h0, out_valid4}, 256'h0);

    // Asynchronous reset while FULL
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_data4 = a4; in_inv4 = 1'b0;
    tick();
    in_data4 = b4;
    tick();
    in_valid4 = 1'b0;
    check("rst_pre_full", {255'h0, in_ready4}, 256'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {255'h0, out_valid4}, 256'h0);
    check("async_rst_ready", {255'h0, in_ready4},  256'h0);
    tick();
    rst_n = 1'b1;
    out_ready4 = 1'b1;
    tick();
    check("rst_no_stale_1", {255'h0, out_valid4}, 256'h0);
    check("rst_ready_back", {255'h0, in_ready4},  256'h1);
    tick();
    check("rst_no_stale_2", {255'h0, out_valid4}, 256'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
